adder_4b: RTL and testbench



---
 rtl/adder_4b_pkg.sv | 16 +
 rtl/adder_4b_full_adder.sv | 18 +
 rtl/adder_4b.sv | 77 +++++++
 tb/tb_adder_4b.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/adder_4b_pkg.sv
// adder_4b_pkg: shared width and types for the registered ripple-carry adder.
//   ADDER_4B_W        - default operand/sum width
//   adder_4b_word_t   - one operand or sum word
//   adder_4b_result_t - packed {c, s} result as presented by the adder
package adder_4b_pkg;

  localparam int ADDER_4B_W = 4;

  typedef logic [ADDER_4B_W-1:0] adder_4b_word_t;

  typedef struct packed {
    logic           c;
    adder_4b_word_t s;
  } adder_4b_result_t;

endpackage

// File: rtl/adder_4b_full_adder.sv
// full_adder: single-bit combinational full adder, one stage of the ripple chain.
// Ports:
//   a, b  - operand bits
//   cin   - carry in from the next-lower stage
//   sum   - a ^ b ^ cin
//   cout  - majority(a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_4b.sv
// adder_4b: registered unsigned ripple-carry adder. Operands sampled under
// in_valid appear as {c, s} one clock later; outputs hold while in_valid is low.
// Optional feature macro: ADDER_4B_OVF_EN adds a registered two's-complement
// overflow flag (ovf).
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   a, b      - unsigned operands
//   in_valid  - operands valid this cycle
//   s         - registered sum (a+b) mod 2^WIDTH
//   c         - registered carry-out
//   out_valid - s/c hold a fresh result
//   ovf       - registered signed overflow (ADDER_4B_OVF_EN only)
module adder_4b
  import adder_4b_pkg::*;
#(
  parameter int WIDTH = ADDER_4B_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             c,
`ifdef ADDER_4B_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  // No carry-in port: the chain always starts from zero.
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

`ifdef ADDER_4B_OVF_EN
  logic ovf_next;

  // Like-signed operands whose sum changes sign overflowed.
  assign ovf_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      c         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s <= sum;
        c <= carry[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_adder_4b.sv
// tb_adder_4b: table-driven and exhaustive bench for adder_4b with a
// queue-based scoreboard of expected register contents.
module tb_adder_4b;
  import adder_4b_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] s;
  logic       c;
  logic       out_valid;
`ifdef ADDER_4B_OVF_EN
  logic       ovf;
`endif

  adder_4b #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .s         (s),
    .c         (c),
`ifdef ADDER_4B_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s;
    logic       c;
    logic       ovf;
    logic       ov;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] s;
    logic       ovf;
  } vec_t;

  exp_t q[$];
  exp_t model;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic act_ovf();
`ifdef ADDER_4B_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_ovf(input logic v);
`ifdef ADDER_4B_OVF_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // Pop the oldest expectation and compare the full output set against it.
  task automatic check_sb(input string name);
    exp_t e;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = q.pop_front();
    n_vec++;
    if ({out_valid, c, s, act_ovf()} !== {e.ov, e.c, e.s, exp_ovf(e.ovf)}) begin
      n_err++;
      $display("FAIL %s: got ov=%0b c=%0b s=%04b ovf=%0b, want ov=%0b c=%0b s=%04b ovf=%0b",
               name, out_valid, c, s, act_ovf(), e.ov, e.c, e.s, exp_ovf(e.ovf));
    end
  endtask

  // Drive one cycle, update the reference register model, push its expectation
  // and compare once the edge has been taken.
  task automatic step(input logic r, input logic v, input logic [3:0] xa,
                      input logic [3:0] xb, input string name);
    logic [4:0] full;
    logic [3:0] xs;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = xa;
    b        = xb;
    full     = {1'b0, xa} + {1'b0, xb};
    xs       = full[3:0];
    if (r) begin
      model = '{s: 4'd0, c: 1'b0, ovf: 1'b0, ov: 1'b0};
    end else if (v) begin
      model.s   = xs;
      model.c   = full[4];
      model.ovf = (xa[3] == xb[3]) && (xs[3] != xa[3]);
      model.ov  = 1'b1;
    end else begin
      model.ov = 1'b0;
    end
    q.push_back(model);
    @(posedge clk);
    #1;
    check_sb(name);
  endtask

  task automatic check_const(input string name, input logic ev, input logic ec,
                             input logic [3:0] es, input logic eo);
    n_vec++;
    if ({out_valid, c, s, act_ovf()} !== {ev, ec, es, exp_ovf(eo)}) begin
      n_err++;
      $display("FAIL %s: got ov=%0b c=%0b s=%04b ovf=%0b, want ov=%0b c=%0b s=%04b ovf=%0b",
               name, out_valid, c, s, act_ovf(), ev, ec, es, exp_ovf(eo));
    end
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{a: 4'd0,  b: 4'd0,  c: 1'b0, s: 4'b0000, ovf: 1'b0};
    vecs[1] = '{a: 4'd0,  b: 4'd15, c: 1'b0, s: 4'b1111, ovf: 1'b0};
    vecs[2] = '{a: 4'd9,  b: 4'd7,  c: 1'b1, s: 4'b0000, ovf: 1'b0};
    vecs[3] = '{a: 4'd15, b: 4'd15, c: 1'b1, s: 4'b1110, ovf: 1'b0};
    vecs[4] = '{a: 4'd8,  b: 4'd7,  c: 1'b0, s: 4'b1111, ovf: 1'b0};
    vecs[5] = '{a: 4'd7,  b: 4'd1,  c: 1'b0, s: 4'b1000, ovf: 1'b1};
    vecs[6] = '{a: 4'd8,  b: 4'd8,  c: 1'b1, s: 4'b0000, ovf: 1'b1};
    vecs[7] = '{a: 4'd15, b: 4'd1,  c: 1'b1, s: 4'b0000, ovf: 1'b0};
    vecs[8] = '{a: 4'd3,  b: 4'd4,  c: 1'b0, s: 4'b0111, ovf: 1'b0};

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    model    = '{s: 4'd0, c: 1'b0, ovf: 1'b0, ov: 1'b0};

    step(1'b1, 1'b0, 4'd0, 4'd0, "reset_a");
    step(1'b1, 1'b0, 4'd0, 4'd0, "reset_b");
    check_const("reset_state", 1'b0, 1'b0, 4'd0, 1'b0);

    // Boundary table
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, vecs[i].a, vecs[i].b, "table_sb");
      check_const($sformatf("table_%0d", i), 1'b1, vecs[i].c, vecs[i].s, vecs[i].ovf);
    end

    // Hold: result stays, out_valid drops, inputs ignored
    step(1'b0, 1'b1, 4'd3, 4'd4, "hold_load");
    check_const("hold_load_k", 1'b1, 1'b0, 4'b0111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'(9 + i), 4'(12 - i), "hold_sb");
      check_const($sformatf("hold_%0d", i), 1'b0, 1'b0, 4'b0111, 1'b0);
    end

    // Reset wins over in_valid, then first operation after release
    step(1'b0, 1'b1, 4'd7, 4'd1, "pre_rst");
    step(1'b1, 1'b1, 4'd15, 4'd1, "rst_prio_sb");
    check_const("rst_prio", 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 4'd1, 4'd1, "post_rst_sb");
    check_const("post_rst", 1'b1, 1'b0, 4'b0010, 1'b0);

    // Exhaustive back-to-back sweep
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 4'(i >> 4), 4'(i & 15), "exhaustive");
    end

    step(1'b0, 1'b0, 4'd0, 4'd0, "tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
